// File: rtl/alu_issue_pkg.sv
// Shared widths, register-file geometry and ALU opcode encoding for the
// operand-issue stage.
package alu_issue_pkg;

    localparam int WORD     = 32;
    localparam int OP_WIDTH = 2;
    localparam int REG_AW   = 3;
    localparam int NREGS    = 1 << REG_AW;

    typedef enum logic [OP_WIDTH-1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_AND = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_e;

endpackage

// File: rtl/alu_issue_regfile.sv
// Register file: three combinational read ports, one write port,
// r0 hardwired to zero and never written.
module alu_issue_regfile
    import alu_issue_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int AW    = REG_AW
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr1,
    output logic [WIDTH-1:0] o_rdata1,
    input  logic [AW-1:0]    i_raddr2,
    output logic [WIDTH-1:0] o_rdata2,
    input  logic [AW-1:0]    i_raddr3,
    output logic [WIDTH-1:0] o_rdata3
);

    localparam int NR = 1 << AW;

    logic [WIDTH-1:0] mem_q [NR];

    // Storage update: synchronous clear, writes to r0 dropped.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NR; i++) begin
                mem_q[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata1 = (i_raddr1 == '0) ? '0 : mem_q[i_raddr1];
    assign o_rdata2 = (i_raddr2 == '0) ? '0 : mem_q[i_raddr2];
    assign o_rdata3 = (i_raddr3 == '0) ? '0 : mem_q[i_raddr3];

endmodule

// File: rtl/alu_issue.sv
// Operand-issue and write-back stage in front of a combinational ALU:
// operand read with forwarding, EX/WB registers, flags and a load port.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter int WIDTH    = WORD,
    parameter int OP_WIDTH = alu_issue_pkg::OP_WIDTH,
    parameter int REG_AW   = alu_issue_pkg::REG_AW
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [OP_WIDTH-1:0] i_opcode,
    input  logic [REG_AW-1:0]   i_rd,
    input  logic [REG_AW-1:0]   i_rs1,
    input  logic [REG_AW-1:0]   i_rs2,
    input  logic                i_ld_valid,
    input  logic [REG_AW-1:0]   i_ld_addr,
    input  logic [WIDTH-1:0]    i_ld_data,
    output logic                o_ld_ready,
    output logic [WIDTH-1:0]    o_alu_a,
    output logic [WIDTH-1:0]    o_alu_b,
    output logic [OP_WIDTH-1:0] o_alu_opcode,
    input  logic [WIDTH-1:0]    i_alu_result,
    input  logic                i_alu_zero,
    input  logic                i_alu_cf,
    output logic                o_wb_valid,
    output logic [REG_AW-1:0]   o_wb_rd,
    output logic [WIDTH-1:0]    o_wb_data,
    output logic                o_zf,
    output logic                o_cf,
    input  logic [REG_AW-1:0]   i_dbg_addr,
    output logic [WIDTH-1:0]    o_dbg_data
);

    logic                ex_valid_q, ex_valid_d;
    logic [WIDTH-1:0]    ex_a_q, ex_a_d;
    logic [WIDTH-1:0]    ex_b_q, ex_b_d;
    logic [OP_WIDTH-1:0] ex_op_q, ex_op_d;
    logic [REG_AW-1:0]   ex_rd_q, ex_rd_d;
    logic                wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0]   wb_rd_q, wb_rd_d;
    logic [WIDTH-1:0]    wb_data_q, wb_data_d;
    logic                zf_q, zf_d;
    logic                cf_q, cf_d;

    logic                accept_s;
    logic                ld_fire_s;
    logic                rf_we_s;
    logic [REG_AW-1:0]   rf_waddr_s;
    logic [WIDTH-1:0]    rf_wdata_s;
    logic [WIDTH-1:0]    rf_rs1_s, rf_rs2_s;
    logic [WIDTH-1:0]    src1_s, src2_s;

    assign o_ready    = !i_ld_valid;
    assign o_ld_ready = !ex_valid_q;
    assign accept_s   = i_valid && o_ready;
    assign ld_fire_s  = i_ld_valid && o_ld_ready;

    // Loads only fire while EX is empty, so the two write sources never collide.
    assign rf_we_s    = ex_valid_q || ld_fire_s;
    assign rf_waddr_s = ex_valid_q ? ex_rd_q : i_ld_addr;
    assign rf_wdata_s = ex_valid_q ? i_alu_result : i_ld_data;

    alu_issue_regfile #(
        .WIDTH (WIDTH),
        .AW    (REG_AW)
    ) u_regfile (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_we     (rf_we_s),
        .i_waddr  (rf_waddr_s),
        .i_wdata  (rf_wdata_s),
        .i_raddr1 (i_rs1),
        .o_rdata1 (rf_rs1_s),
        .i_raddr2 (i_rs2),
        .o_rdata2 (rf_rs2_s),
        .i_raddr3 (i_dbg_addr),
        .o_rdata3 (o_dbg_data)
    );

    // The in-flight result is newer than the regfile; r0 never forwards.
    assign src1_s = (ex_valid_q && (i_rs1 == ex_rd_q) && (i_rs1 != '0)) ? i_alu_result : rf_rs1_s;
    assign src2_s = (ex_valid_q && (i_rs2 == ex_rd_q) && (i_rs2 != '0)) ? i_alu_result : rf_rs2_s;

    // Next-state for EX, WB and flag registers.
    always_comb begin
        ex_valid_d = accept_s;
        ex_a_d     = ex_a_q;
        ex_b_d     = ex_b_q;
        ex_op_d    = ex_op_q;
        ex_rd_d    = ex_rd_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        zf_d       = zf_q;
        cf_d       = cf_q;
        if (accept_s) begin
            ex_a_d  = src1_s;
            ex_b_d  = src2_s;
            ex_op_d = i_opcode;
            ex_rd_d = i_rd;
        end else begin
            ex_a_d  = ex_a_q;
        end
        if (ex_valid_q) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd_q;
            wb_data_d  = i_alu_result;
            zf_d       = i_alu_zero;
            cf_d       = i_alu_cf;
        end else begin
            wb_valid_d = 1'b0;
        end
    end

    // Pipeline state registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_valid_q <= 1'b0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            ex_op_q    <= '0;
            ex_rd_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            zf_q       <= 1'b0;
            cf_q       <= 1'b0;
        end else begin
            ex_valid_q <= ex_valid_d;
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_op_q    <= ex_op_d;
            ex_rd_q    <= ex_rd_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            zf_q       <= zf_d;
            cf_q       <= cf_d;
        end
    end

    assign o_alu_a      = ex_a_q;
    assign o_alu_b      = ex_b_q;
    assign o_alu_opcode = ex_op_q;
    assign o_wb_valid   = wb_valid_q;
    assign o_wb_rd      = wb_rd_q;
    assign o_wb_data    = wb_data_q;
    assign o_zf         = zf_q;
    assign o_cf         = cf_q;

endmodule
